// File: rtl/lms_adapt_ctrl_pkg.sv
// Shared state encoding and defaults for the LMS adaptation sequencer.
package lms_adapt_ctrl_pkg;

    // State codes are visible on o_state, so the values are fixed.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFlush  = 3'd1,
        StWarmup = 3'd2,
        StAdapt  = 3'd3,
        StFrozen = 3'd4
    } lms_state_e;

    localparam int unsigned OsFactorDefault = 2;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lms_adapt_ctrl.sv
// Sequencer that turns sample and slicer-error strobes into LMS shift/save/update controls,
// with warm-up, update decimation, freeze and overrun detection.
module lms_adapt_ctrl
    import lms_adapt_ctrl_pkg::*;
#(
    parameter int unsigned OS_FACTOR  = OsFactorDefault,
    parameter int unsigned NB_CNT     = 16,
    parameter int unsigned NB_DEC     = 8,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic                             i_stop,
    input  logic                             i_valid,
    input  logic                             i_err_valid,
    input  logic [cnt_width(OS_FACTOR)-1:0]  i_phase_sel,
    input  logic [NB_CNT-1:0]                i_warmup_sym,
    input  logic [NB_DEC-1:0]                i_upd_every,
    input  logic                             i_freeze,
    output logic                             o_en_shtr,
    output logic                             o_save_shftrs,
    output logic                             o_en_taps,
    output logic                             o_lms_reset,
    output logic [2:0]                       o_state,
    output logic                             o_adapting,
    output logic                             o_overrun,
    output logic [NB_CNT-1:0]                o_upd_cnt
);

    localparam int unsigned PhW = cnt_width(OS_FACTOR);
    localparam int unsigned RcW = cnt_width(RST_CYCLES);
    localparam logic [PhW-1:0] PhaseLast = PhW'(OS_FACTOR - 1);
    localparam logic [RcW-1:0] RstLast   = RcW'(RST_CYCLES - 1);

    lms_state_e          state_q, state_d;
    logic [PhW-1:0]      phase_q, phase_d;
    logic [RcW-1:0]      rst_cnt_q, rst_cnt_d;
    logic [NB_CNT-1:0]   warm_cnt_q, warm_cnt_d;
    logic [NB_DEC-1:0]   dec_cnt_q, dec_cnt_d;
    logic [NB_CNT-1:0]   upd_cnt_q, upd_cnt_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic                save_dly_q, save_dly_d;  // symbol-aligned shift seen, capture next cycle
    logic                shtr_q, shtr_d;
    logic                save_q, save_d;
    logic                taps_q, taps_d;
    logic                lms_rst_q, lms_rst_d;
    logic                adapting_q, adapting_d;

    logic active;
    logic save_evt;
    logic consume;

    // Next-state logic for the FSM, counters and registered outputs.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rst_cnt_d  = rst_cnt_q;
        warm_cnt_d = warm_cnt_q;
        dec_cnt_d  = dec_cnt_q;
        upd_cnt_d  = upd_cnt_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        save_dly_d = 1'b0;
        shtr_d     = 1'b0;
        save_d     = 1'b0;
        taps_d     = 1'b0;

        active   = (state_q == StWarmup) || (state_q == StAdapt) || (state_q == StFrozen);
        // The capture happens the cycle o_save_shftrs rises; pending tracks that moment.
        save_evt = active && save_dly_q;
        consume  = (state_q == StAdapt) && !i_freeze && i_err_valid && pending_q;

        if (i_stop) begin
            state_d   = StIdle;
            phase_d   = '0;
            pending_d = 1'b0;
            dec_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_d   = StFlush;
                        rst_cnt_d = '0;
                        overrun_d = 1'b0;
                        upd_cnt_d = '0;
                    end
                end
                StFlush: begin
                    phase_d    = '0;
                    warm_cnt_d = '0;
                    dec_cnt_d  = '0;
                    pending_d  = 1'b0;
                    if (rst_cnt_q == RstLast) begin
                        state_d = (i_warmup_sym == '0) ? StAdapt : StWarmup;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                StWarmup: begin
                    // Saves here do not arm pending: no error can be consumed before ADAPT.
                    if (save_evt) begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                        if (warm_cnt_d >= i_warmup_sym) begin
                            state_d = StAdapt;
                        end
                    end
                end
                StAdapt: begin
                    if (i_freeze) begin
                        state_d   = StFrozen;
                        pending_d = 1'b0;
                    end else begin
                        if (consume) begin
                            pending_d = 1'b0;
                            taps_d    = (dec_cnt_q == '0);
                            dec_cnt_d = (dec_cnt_q == i_upd_every) ? '0 : dec_cnt_q + 1'b1;
                        end
                        // Consume applies to the old pending first, so no overrun then.
                        if (save_evt) begin
                            if (pending_q && !consume) begin
                                overrun_d = 1'b1;
                            end
                            pending_d = 1'b1;
                        end
                    end
                end
                StFrozen: begin
                    pending_d = 1'b0;
                    if (!i_freeze) begin
                        state_d   = StAdapt;
                        dec_cnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (active) begin
                shtr_d = i_valid;
                save_d = save_dly_q;
                if (i_valid) begin
                    save_dly_d = (phase_q == i_phase_sel);
                    phase_d    = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
                end
            end
        end

        if (taps_d && (upd_cnt_q != '1)) begin
            upd_cnt_d = upd_cnt_q + 1'b1;
        end

        lms_rst_d  = (state_d == StIdle) || (state_d == StFlush);
        adapting_d = (state_d == StAdapt);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            rst_cnt_q  <= '0;
            warm_cnt_q <= '0;
            dec_cnt_q  <= '0;
            upd_cnt_q  <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            save_dly_q <= 1'b0;
            shtr_q     <= 1'b0;
            save_q     <= 1'b0;
            taps_q     <= 1'b0;
            lms_rst_q  <= 1'b1;
            adapting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rst_cnt_q  <= rst_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            upd_cnt_q  <= upd_cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            save_dly_q <= save_dly_d;
            shtr_q     <= shtr_d;
            save_q     <= save_d;
            taps_q     <= taps_d;
            lms_rst_q  <= lms_rst_d;
            adapting_q <= adapting_d;
        end
    end

    assign o_en_shtr     = shtr_q;
    assign o_save_shftrs = save_q;
    assign o_en_taps     = taps_q;
    assign o_lms_reset   = lms_rst_q;
    assign o_state       = state_q;
    assign o_adapting    = adapting_q;
    assign o_overrun     = overrun_q;
    assign o_upd_cnt     = upd_cnt_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Directed bench for lms_adapt_ctrl: flush, warm-up, decimated adaptation, overrun,
// freeze/release, stop and asynchronous reset.
module tb_lms_adapt_ctrl;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_err_valid = 1'b0;
    logic [0:0]  i_phase_sel = '0;
    logic [15:0] i_warmup_sym = 16'd3;
    logic [7:0]  i_upd_every = 8'd2;
    logic        i_freeze = 1'b0;
    logic        o_en_shtr;
    logic        o_save_shftrs;
    logic        o_en_taps;
    logic        o_lms_reset;
    logic [2:0]  o_state;
    logic        o_adapting;
    logic        o_overrun;
    logic [15:0] o_upd_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_shtr, n_save, n_taps, n_save_early;
    int last_taps;

    lms_adapt_ctrl dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_valid       (i_valid),
        .i_err_valid   (i_err_valid),
        .i_phase_sel   (i_phase_sel),
        .i_warmup_sym  (i_warmup_sym),
        .i_upd_every   (i_upd_every),
        .i_freeze      (i_freeze),
        .o_en_shtr     (o_en_shtr),
        .o_save_shftrs (o_save_shftrs),
        .o_en_taps     (o_en_taps),
        .o_lms_reset   (o_lms_reset),
        .o_state       (o_state),
        .o_adapting    (o_adapting),
        .o_overrun     (o_overrun),
        .o_upd_cnt     (o_upd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive strobes, take the edge, observe 1 time unit later.
    task automatic step(input logic v, input logic e, input bit first);
        i_valid     = v;
        i_err_valid = e;
        @(posedge clk);
        #1;
        n_shtr += int'(o_en_shtr);
        n_save += int'(o_save_shftrs);
        n_taps += int'(o_en_taps);
        if (first && o_save_shftrs) n_save_early++;
        last_taps = int'(o_en_taps);
        i_valid     = 1'b0;
        i_err_valid = 1'b0;
    endtask

    // Two clocks: strobe(s) in the first, idle in the second (sample spacing 2).
    task automatic pair(input logic v, input logic e);
        step(v, e, 1'b1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        n_shtr = 0; n_save = 0; n_taps = 0; n_save_early = 0;
    endtask

    // Start, flush and warm up with 3 symbols; ends with the DUT just entered ADAPT.
    task automatic start_and_warmup(input string pfx);
        int rst_cycles;
        rst_cycles = 0;
        i_start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        i_start = 1'b0;
        check_eq({pfx, "_state_flush"}, 32'(o_state), 32'd1);
        check_eq({pfx, "_overrun_cleared"}, 32'(o_overrun), 32'd0);
        check_eq({pfx, "_updcnt_cleared"}, 32'(o_upd_cnt), 32'd0);
        for (int i = 0; i < 20 && o_lms_reset; i++) begin
            rst_cycles++;
            step(1'b0, 1'b0, 1'b0);
        end
        check_eq({pfx, "_lms_reset_len"}, 32'(rst_cycles), 32'd4);
        check_eq({pfx, "_state_warmup"}, 32'(o_state), 32'd2);
        clear_counts();
        for (int i = 0; i < 4; i++) pair(1'b1, 1'b0);
        check_eq({pfx, "_still_warmup"}, 32'(o_state), 32'd2);
        pair(1'b1, 1'b0);
        check_eq({pfx, "_state_adapt"}, 32'(o_state), 32'd3);
        check_eq({pfx, "_adapting"}, 32'(o_adapting), 32'd1);
        check_eq({pfx, "_warm_shifts"}, 32'(n_shtr), 32'd5);
        check_eq({pfx, "_warm_saves"}, 32'(n_save), 32'd3);
        check_eq({pfx, "_save_not_early"}, 32'(n_save_early), 32'd0);
        check_eq({pfx, "_warm_no_taps"}, 32'(n_taps), 32'd0);
    endtask

    initial begin
        clear_counts();
        last_taps = 0;
        i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(o_state), 32'd0);
        check_eq("rst_lms_reset", 32'(o_lms_reset), 32'd1);
        check_eq("rst_enables", 32'({o_en_shtr, o_save_shftrs, o_en_taps, o_adapting}), 32'd0);
        check_eq("rst_overrun_updcnt", 32'({o_overrun, o_upd_cnt}), 32'd0);
        i_reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        start_and_warmup("s1");

        // Phase is now 1: the next valid is off-symbol, the one after that saves.
        pair(1'b1, 1'b0);
        pair(1'b1, 1'b0);
        // Nine errors, each 1 cycle after a save; taps expected on errors 1, 4, 7.
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 1'b1, 1'b1);
            check_eq($sformatf("dec_taps_err%0d", k + 1), 32'(last_taps),
                     (k % 3 == 0) ? 32'd1 : 32'd0);
            step(1'b0, 1'b0, 1'b0);
            pair(1'b1, 1'b0);
        end
        check_eq("dec_upd_cnt", 32'(o_upd_cnt), 32'd3);
        check_eq("no_overrun_yet", 32'(o_overrun), 32'd0);

        // Second save with no error between -> sticky overrun.
        pair(1'b1, 1'b0);
        pair(1'b1, 1'b0);
        check_eq("overrun_set", 32'(o_overrun), 32'd1);

        // Tenth consumed error lands on dec_cnt 0; the stray error after it is ignored.
        step(1'b1, 1'b1, 1'b1);
        check_eq("tenth_err_taps", 32'(last_taps), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_eq("stray_err_no_taps", 32'(last_taps), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("upd_cnt_4", 32'(o_upd_cnt), 32'd4);
        check_eq("overrun_sticky", 32'(o_overrun), 32'd1);

        // Freeze: shifts and saves keep going, errors never update taps.
        i_freeze = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_eq("state_frozen", 32'(o_state), 32'd4);
        check_eq("frozen_not_adapting", 32'(o_adapting), 32'd0);
        clear_counts();
        for (int i = 0; i < 4; i++) pair(1'b1, 1'b1);
        check_eq("frozen_shifts", 32'(n_shtr), 32'd4);
        check_eq("frozen_saves", 32'(n_save), 32'd2);
        check_eq("frozen_no_taps", 32'(n_taps), 32'd0);

        // Release: first consumed error updates (dec_cnt restarted at 0).
        i_freeze = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check_eq("state_released", 32'(o_state), 32'd3);
        pair(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_eq("release_first_taps", 32'(last_taps), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("upd_cnt_5", 32'(o_upd_cnt), 32'd5);

        // Stop mid-ADAPT, with a shift in flight.
        i_stop = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        i_stop = 1'b0;
        check_eq("stop_state", 32'(o_state), 32'd0);
        check_eq("stop_lms_reset", 32'(o_lms_reset), 32'd1);
        check_eq("stop_enables", 32'({o_en_shtr, o_save_shftrs, o_en_taps, o_adapting}), 32'd0);
        check_eq("stop_keeps_overrun", 32'(o_overrun), 32'd1);
        check_eq("stop_keeps_updcnt", 32'(o_upd_cnt), 32'd5);
        step(1'b0, 1'b0, 1'b0);

        start_and_warmup("s2");

        // Asynchronous reset between clock edges mid-ADAPT.
        pair(1'b1, 1'b0);
        #3;
        i_reset = 1'b0;
        #1;
        check_eq("areset_state", 32'(o_state), 32'd0);
        check_eq("areset_lms_reset", 32'(o_lms_reset), 32'd1);
        check_eq("areset_enables", 32'({o_en_shtr, o_save_shftrs, o_en_taps, o_adapting}), 32'd0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        start_and_warmup("s3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
